// File: rtl/ring_osc_freq_meter.sv
// rtl/ring_osc_freq_meter.sv - ring-oscillator edge counter over a fixed clk gate window
// Synchronises osc_in, counts its rising edges for GATE_CYCLES clocks and latches the result.
module ring_osc_freq_meter #(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  input  logic             start,
  input  logic             cont,
  input  logic [1:0]       byte_sel,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  output logic             busy,
  output logic             overflow,
  output logic [7:0]       data_byte
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic             rise;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] edge_cnt, cnt_next;
  logic             sat_q, sat_next;
  logic             win_end;
  logic             arm;
  logic [31:0]      cnt_ext;

  // s3 is only a history flop for edge detection, not a third sync stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_comb begin
    cnt_next = edge_cnt;
    sat_next = sat_q;
    if (rise) begin
      if (&edge_cnt) sat_next = 1'b1;
      else           cnt_next = edge_cnt + CNT_W'(1);
    end
  end

  assign win_end = (state_q == MEASURE) && (gate_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || cont) begin
          state_d = MEASURE;
          arm     = 1'b1;
        end
      end
      MEASURE: begin
        if (gate_q == '0) begin
          if (cont) arm = 1'b1;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Re-arming on the last gate cycle keeps back-to-back windows gapless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q    <= '0;
      edge_cnt  <= '0;
      sat_q     <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= win_end;
      if (arm) begin
        gate_q   <= GATE_LOAD;
        edge_cnt <= '0;
        sat_q    <= 1'b0;
      end else if (state_q == MEASURE) begin
        gate_q   <= gate_q - GW'(1);
        edge_cnt <= cnt_next;
        sat_q    <= sat_next;
      end
      if (win_end) begin
        count_out <= cnt_next;
        overflow  <= sat_next;
      end
    end
  end

  assign busy = (state_q == MEASURE);

  always_comb begin
    cnt_ext              = '0;
    cnt_ext[CNT_W-1:0]   = count_out;
    data_byte            = cnt_ext[{byte_sel, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// tb/tb_ring_osc_freq_meter.sv - scoreboard bench for ring_osc_freq_meter
// Two instances (8- and 16-bit results) share stimulus; expected counts come from sampled osc history.
module tb_ring_osc_freq_meter;

  localparam int G = 1024;

  logic clk = 1'b0, rst_n = 1'b0, osc_in = 1'b0, start = 1'b0, cont = 1'b0;
  logic [1:0] byte_sel = 2'd0;
  logic [7:0]  c8, d8, d16;
  logic [15:0] c16;
  logic v8, b8, o8, v16, b16, o16;

  ring_osc_freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .cont(cont),
    .byte_sel(byte_sel), .count_out(c8), .valid(v8), .busy(b8),
    .overflow(o8), .data_byte(d8));

  ring_osc_freq_meter #(.GATE_CYCLES(G), .CNT_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .cont(cont),
    .byte_sel(byte_sel), .count_out(c16), .valid(v16), .busy(b16),
    .overflow(o16), .data_byte(d16));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int exp_q[$];
  bit samp[0:65535];
  int cyc = 0;
  int ws = 0;
  bit m_busy = 1'b0, m_valid = 1'b0;
  int osc_mode = 0, osc_hi = 4, osc_lo = 4;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // A window starting at edge s covers synchronised rises whose sample index lies in [s-1, s+G-2].
  function automatic int count_win(input int s);
    int n = 0;
    for (int r = s - 1; r <= s + G - 2; r++)
      if (r >= 1 && samp[r] && !samp[r-1]) n++;
    return n;
  endfunction

  // Reference model: window bookkeeping at each clock edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    samp[cyc] = rst_n ? osc_in : 1'b0;
    m_valid = 1'b0;
    if (rst_n) begin
      if (m_busy) begin
        if (cyc == ws + G) begin
          exp_q.push_back(count_win(ws));
          m_valid = 1'b1;
          if (cont) ws = cyc;
          else      m_busy = 1'b0;
        end
      end else if (start || cont) begin
        m_busy = 1'b1;
        ws = cyc;
      end
    end
  end

  // Oscillator and byte_sel generator.
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      byte_sel = 2'($urandom);
      if (osc_mode == 0) osc_in = 1'b0;
      else if (osc_mode == 1) osc_in = 1'b1;
      else begin
        ph++;
        if (osc_in && ph >= osc_hi) begin osc_in = 1'b0; ph = 0; end
        else if (!osc_in && ph >= osc_lo) begin osc_in = 1'b1; ph = 0; end
      end
    end
  end

  // Monitor.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      chk("busy8", b8, m_busy);
      chk("busy16", b16, m_busy);
      chk("valid8", v8, m_valid);
      chk("valid16", v16, m_valid);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          int raw, e8, e16, bs;
          raw = exp_q.pop_front();
          e8  = (raw > 255) ? 255 : raw;
          e16 = raw;
          bs  = int'(byte_sel);
          chk("count8", c8, e8);
          chk("ovf8", o8, raw > 255);
          chk("count16", c16, e16);
          chk("ovf16", o16, 0);
          chk("byte8", d8, (bs == 0) ? e8 : 0);
          chk("byte16", d16, (bs < 2) ? ((e16 >> (8 * bs)) & 255) : 0);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_count8"}, c8, 0);
    chk({nm, "_count16"}, c16, 0);
    chk({nm, "_valid"}, v8 | v16, 0);
    chk({nm, "_busy"}, b8 | b16, 0);
    chk({nm, "_ovf"}, o8 | o16, 0);
  endtask

  task automatic set_osc(input int mode, input int hi, input int lo);
    osc_mode = mode; osc_hi = hi; osc_lo = lo;
  endtask

  initial begin
    #3;
    check_zero("reset");
    chk("reset_byte", d8 | d16, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // clk/8 single window, then static low and high inputs
    set_osc(2, 4, 4);
    wait_cyc(20);
    pulse_start();
    wait_cyc(G + 40);
    set_osc(0, 4, 4);
    wait_cyc(10);
    pulse_start();
    wait_cyc(G + 40);
    set_osc(1, 4, 4);
    wait_cyc(10);
    pulse_start();
    wait_cyc(G + 40);

    // clk/4 saturates the 8-bit instance; clk/16 follows
    set_osc(2, 2, 2);
    pulse_start();
    wait_cyc(G + 40);
    set_osc(2, 8, 8);
    pulse_start();
    wait_cyc(G + 40);

    // continuous mode, dropped mid-window
    set_osc(2, 4, 4);
    @(negedge clk); cont = 1'b1;
    wait_cyc(4 * G + 300);
    cont = 1'b0;
    wait_cyc(G + 40);

    // start while busy is ignored
    pulse_start();
    wait_cyc(100);
    pulse_start();
    wait_cyc(G + 40);

    // reset mid-window
    pulse_start();
    wait_cyc(500);
    #2;
    rst_n = 1'b0;
    m_busy = 1'b0;
    m_valid = 1'b0;
    exp_q.delete();
    #1;
    check_zero("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    wait_cyc(G + 200);
    pulse_start();
    wait_cyc(G + 40);

    // randomised oscillator shapes, occasional ignored restarts
    for (int i = 0; i < 5; i++) begin
      set_osc(2, $urandom_range(2, 12), $urandom_range(2, 12));
      wait_cyc($urandom_range(1, 30));
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        wait_cyc($urandom_range(1, G - 50));
        pulse_start();
      end
      wait_cyc(G + 60);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
